// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX definitions: framing constants, CRC-32 parameters,
// byte-counter width, framer state encoding and FCS byte selection.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  // Frame byte counter width; the counter saturates at its all-ones value.
  localparam int unsigned BYTE_CNT_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    SEG,
    PAD,
    FCS,
    IFG
  } eth_tx_state_t;

  // FCS is the inverted CRC register sent least-significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                          input logic [1:0]  idx);
    logic [31:0] w_inv;
    w_inv = ~crc;
    return w_inv[8*idx +: 8];
  endfunction

endpackage

// File: rtl/eth_tx_framer_crc32_d8.sv
// Combinational byte-wide update of a reflected CRC-32 (poly 0xEDB88320).
// Ports:
//   i_crc  [31:0]  current CRC register
//   i_data [7:0]   byte to absorb, bit 0 first
//   o_crc  [31:0]  CRC after absorbing i_data
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  // Eight unrolled shift/xor steps of the reflected LFSR.
  always_comb begin
    w_crc = i_crc ^ {24'h000000, i_data};
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0]) begin
        w_crc = (w_crc >> 1) ^ CRC32_POLY;
      end else begin
        w_crc = w_crc >> 1;
      end
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, concatenation of NUM_SEG byte
// sources in index order, zero padding to MIN_FRAME, CRC-32 FCS and IFG.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             frame request, sampled only in IDLE
//   seg_data/valid/last  per-segment byte sources (segment i at [8i+7:8i])
//   seg_ready         one-hot, combinational consume strobe for segment i
//   tx_data/valid/err registered byte stream toward rgmii_tx
//   busy              high in every state except IDLE
//   frame_done        pulse with the last FCS byte of a good frame
//   underrun          pulse on a source stall mid-frame (abort)
//   oversize          pulse when MAX_FRAME would be exceeded (abort)
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned NUM_SEG      = 3,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned MAX_FRAME    = 1514,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_SEG*8-1:0] seg_data,
  input  logic [NUM_SEG-1:0]   seg_valid,
  input  logic [NUM_SEG-1:0]   seg_last,
  output logic [NUM_SEG-1:0]   seg_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 tx_err,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 oversize
);

  localparam int unsigned IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned IFG_W = $clog2(IFG_LEN + 1);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_SEG - 1);
  localparam logic [BYTE_CNT_W-1:0] MIN_CNT  = BYTE_CNT_W'(MIN_FRAME);
  localparam logic [BYTE_CNT_W-1:0] MAX_CNT  = BYTE_CNT_W'(MAX_FRAME);
  localparam logic [BYTE_CNT_W-1:0] SAT_CNT  = '1;

  eth_tx_state_t         r_state;
  logic [PRE_W-1:0]      r_pre_cnt;
  logic [IFG_W-1:0]      r_ifg_cnt;
  logic [1:0]            r_fcs_idx;
  logic [IDX_W-1:0]      r_seg_idx;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [31:0]           r_crc;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_tx_err;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_underrun;
  logic                  r_oversize;

  logic                  w_cur_valid;
  logic                  w_cur_last;
  logic [7:0]            w_cur_data;
  logic                  w_take;
  logic [7:0]            w_crc_din;
  logic [31:0]           w_crc_next;
  logic [BYTE_CNT_W-1:0] w_cnt_inc;

  // Select the active segment's source signals.
  always_comb begin
    w_cur_valid = 1'b0;
    w_cur_last  = 1'b0;
    w_cur_data  = 8'h00;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (r_seg_idx == IDX_W'(i)) begin
        w_cur_valid = seg_valid[i];
        w_cur_last  = seg_last[i];
        w_cur_data  = seg_data[8*i +: 8];
      end
    end
  end

  // A byte is taken only in SEG and only while it still fits in MAX_FRAME.
  assign w_take = (r_state == SEG) && w_cur_valid && (r_byte_cnt < MAX_CNT);

  always_comb begin
    seg_ready = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      seg_ready[i] = w_take && (r_seg_idx == IDX_W'(i));
    end
  end

  assign w_crc_din = (r_state == PAD) ? 8'h00 : w_cur_data;
  assign w_cnt_inc = (r_byte_cnt == SAT_CNT) ? r_byte_cnt
                                             : r_byte_cnt + BYTE_CNT_W'(1);

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_din),
    .o_crc  (w_crc_next)
  );

  // Framer FSM; each edge registers the byte chosen by the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pre_cnt    <= '0;
      r_ifg_cnt    <= '0;
      r_fcs_idx    <= '0;
      r_seg_idx    <= '0;
      r_byte_cnt   <= '0;
      r_crc        <= CRC32_INIT;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_err     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_oversize   <= 1'b0;
    end else begin
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_err     <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_oversize   <= 1'b0;

      case (r_state)
        IDLE: begin
          r_busy <= start;
          if (start) begin
            // The first preamble byte leaves on the same edge that samples start.
            r_tx_data  <= ETH_PREAMBLE;
            r_tx_valid <= 1'b1;
            r_pre_cnt  <= PRE_W'(1);
            r_state    <= (PREAMBLE_LEN > 1) ? PRE : SFD;
          end
        end

        PRE: begin
          r_tx_data  <= ETH_PREAMBLE;
          r_tx_valid <= 1'b1;
          r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
          if (r_pre_cnt == PRE_W'(PREAMBLE_LEN - 1)) begin
            r_state <= SFD;
          end
        end

        SFD: begin
          r_tx_data  <= ETH_SFD;
          r_tx_valid <= 1'b1;
          r_crc      <= CRC32_INIT;
          r_seg_idx  <= '0;
          r_byte_cnt <= '0;
          r_fcs_idx  <= '0;
          r_state    <= SEG;
        end

        SEG: begin
          if (!w_cur_valid) begin
            // Source stall: one error symbol, then abandon the frame.
            r_tx_valid <= 1'b1;
            r_tx_err   <= 1'b1;
            r_underrun <= 1'b1;
            r_ifg_cnt  <= '0;
            r_state    <= IFG;
          end else if (!w_take) begin
            r_tx_valid <= 1'b1;
            r_tx_err   <= 1'b1;
            r_oversize <= 1'b1;
            r_ifg_cnt  <= '0;
            r_state    <= IFG;
          end else begin
            r_tx_data  <= w_cur_data;
            r_tx_valid <= 1'b1;
            r_crc      <= w_crc_next;
            r_byte_cnt <= w_cnt_inc;
            if (w_cur_last) begin
              if (r_seg_idx == LAST_IDX) begin
                r_state <= (w_cnt_inc < MIN_CNT) ? PAD : FCS;
              end else begin
                r_seg_idx <= r_seg_idx + IDX_W'(1);
              end
            end
          end
        end

        PAD: begin
          r_tx_valid <= 1'b1;
          r_crc      <= w_crc_next;
          r_byte_cnt <= w_cnt_inc;
          if (w_cnt_inc >= MIN_CNT) begin
            r_state <= FCS;
          end
        end

        FCS: begin
          r_tx_data  <= fcs_byte(r_crc, r_fcs_idx);
          r_tx_valid <= 1'b1;
          r_fcs_idx  <= r_fcs_idx + 2'd1;
          if (r_fcs_idx == 2'd3) begin
            r_frame_done <= 1'b1;
            r_ifg_cnt    <= '0;
            r_state      <= IFG;
          end
        end

        IFG: begin
          r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
          if (r_ifg_cnt == IFG_W'(IFG_LEN - 1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign tx_err     = r_tx_err;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;
  assign oversize   = r_oversize;

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
Parametrised Ethernet transmit framer that replaces the hard-coded eth/ip/udp three-state byte sequencer ahead of rgmii_tx.
- Concatenates NUM_SEG byte-wide source segments (e.g. MAC header, IP header, UDP payload) in index order into one frame.
- Prepends preamble/SFD, pads to minimum length, appends CRC-32 FCS, and enforces the inter-frame gap.
- Output is a byte stream with valid/error qualifiers, consumed each cycle by rgmii_tx.

Parameters:
NUM_SEG, 3, number of input segments, 1..8
MIN_FRAME, 60, minimum frame bytes (DA through payload, excluding FCS) before padding stops
MAX_FRAME, 1514, maximum frame bytes excluding FCS; exceeding it aborts the frame
PREAMBLE_LEN, 7, count of 0x55 bytes before the SFD
IFG_LEN, 12, idle cycles after a frame before the next start is accepted

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
start  in  1  request one frame; sampled only in IDLE
seg_data  in  NUM_SEG*8  segment i occupies bits [8i+7:8i]
seg_valid  in  NUM_SEG  segment i byte available
seg_last  in  NUM_SEG  marks the final byte of segment i
seg_ready  out  NUM_SEG  one-hot; byte of segment i consumed this cycle
tx_data  out  8  output byte
tx_valid  out  1  frame byte present (preamble through FCS)
tx_err  out  1  error symbol; asserted with tx_valid
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on a good frame's last FCS byte
underrun  out  1  one-cycle pulse on a mid-frame source stall
oversize  out  1  one-cycle pulse on MAX_FRAME exceeded

Behaviour:
- Reset: state=IDLE; tx_data=0x00; tx_valid, tx_err, busy, frame_done, underrun, oversize, seg_ready all 0; CRC register=0xFFFFFFFF; all counters 0. Reset mid-frame ends the frame immediately, with no FCS and no IFG.
- Outputs are registered. The first preamble byte appears on tx_data in the cycle after start is sampled high in IDLE.
- States and transitions:
  - IDLE -> PRE on start.
  - PRE emits 0x55 PREAMBLE_LEN times, then -> SFD.
  - SFD emits 0xD5; CRC is initialised to 0xFFFFFFFF; seg_idx=0; then -> SEG.
- SEG:
  - seg_ready[seg_idx] = seg_valid[seg_idx] (combinational; no other ready bit asserted).
  - On the handshake: tx_data=seg byte, byte_cnt++, CRC updated.
  - On seg_last, seg_idx++.
  - After the last byte of segment NUM_SEG-1: -> PAD if byte_cnt<MIN_FRAME, else -> FCS.
  - Segment switch costs no bubble; the next segment's byte may be taken in the following cycle.
- Underrun: in SEG, seg_valid[seg_idx]=0 means no handshake.
  - That cycle emits tx_valid=1, tx_err=1, tx_data=0x00 and pulses underrun.
  - Then -> IFG; remaining source bytes are not drained.
  - Sources must hold valid continuously once their segment is active.
- Oversize: a handshake that would make byte_cnt exceed MAX_FRAME is not accepted (seg_ready stays 0). Instead tx_err=1 and oversize pulses, then -> IFG.
- PAD emits 0x00 through the CRC until byte_cnt==MIN_FRAME, then -> FCS.
- FCS emits ~CRC as 4 bytes, LSB first.
  - CRC-32 is reflected with polynomial 0xEDB88320.
  - frame_done pulses with the 4th byte; then -> IFG.
- IFG: tx_valid=0 for IFG_LEN cycles; start is ignored; then -> IDLE. busy stays 1 through IFG.
- byte_cnt is 11 bits and saturates at 2047; it never wraps.
- tx_err is 0 in all states except the abort cycle.
- Zero-length segment: seg_last on the first byte means a 1-byte segment. Empty segments are unsupported.
- Simultaneous events: seg_last on the final segment with byte_cnt reaching exactly MIN_FRAME goes directly to FCS, with no PAD cycle.

Decomposition:
- Shared package eth_pkg holds:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF;
  - the state enum IDLE/PRE/SFD/SEG/PAD/FCS/IFG.
- Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]), reused by the future RX checker.

Test Plan:
1. MIN_FRAME=9, NUM_SEG=1, bytes "123456789" (0x31..0x39), continuous valid -> 7x55, D5, 31..39, then FCS 26 39 F4 CB; frame_done on CB; 12 idle cycles.
2. Defaults, segments of 14/20/8 bytes -> 42 data bytes, 18 bytes of 0x00 pad, 4 FCS bytes; 72 tx_valid cycles total; seg_ready one-hot with no bubble at segment boundaries.
3. Stall: drop seg_valid[1] after its 5th byte -> one tx_err cycle, underrun pulse, no FCS, no frame_done, 12 IFG cycles, busy low afterwards.
4. MAX_FRAME=64, a 100-byte segment -> 64 data bytes accepted, next cycle tx_err+oversize, seg_ready never high for byte 65.
5. start held high continuously -> consecutive frames separated by exactly 12 tx_valid-low cycles; a start pulse during IFG is ignored.
6. rst asserted mid-SEG -> all outputs 0 asynchronously; a new start after release yields a correct, complete frame.
